// File: rtl/uart_pkg.sv
// Constants and state encodings shared by the UART transmitter and receiver,
// so both directions decode identically in traces.
package uart_pkg;

    localparam int TICKS_PER_BIT = 16;
    localparam int MID_SAMPLE    = 7;
    localparam int DATA_BITS     = 8;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START_BIT = 3'd1,
        S_DATA_BITS = 3'd2,
        S_STOP_BIT  = 3'd3,
        S_DONE      = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter (8 data bits, no parity, 1 or 2 stop bits) paced by the
// shared 16x baud tick, with a one-entry holding register in front of the shifter.
module uart_tx
    import uart_pkg::*;
#(
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_16x,
    input  logic       tx_start,
    input  logic [7:0] data_in,
    output logic       serial_out,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done_pulse,
    output logic [2:0] state_dbg
);

    localparam logic [3:0] TICK_LAST = 4'(TICKS_PER_BIT - 1);
    localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic [4:0] STOP_LAST = 5'(TICKS_PER_BIT * STOP_BITS - 1);

    generate
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
            $error("uart_tx: STOP_BITS must be 1 or 2");
        end
    endgenerate

    // Handshake: the producer may pulse tx_start in any cycle; the byte on
    // data_in is taken only when tx_ready (holding register empty) is high in
    // that same cycle, otherwise the request is dropped without side effects.

    uart_state_e state_q, state_d;
    logic [7:0]  hold_data_q, hold_data_d;
    logic        hold_valid_q, hold_valid_d;
    logic [7:0]  shift_q, shift_d;
    logic [3:0]  tick_cnt_q, tick_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [4:0]  stop_cnt_q, stop_cnt_d;
    logic        serial_q, serial_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            hold_data_q  <= 8'h00;
            hold_valid_q <= 1'b0;
            shift_q      <= 8'h00;
            tick_cnt_q   <= 4'd0;
            bit_idx_q    <= 3'd0;
            stop_cnt_q   <= 5'd0;
            serial_q     <= 1'b1;
        end else begin
            state_q      <= state_d;
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
            shift_q      <= shift_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_idx_q    <= bit_idx_d;
            stop_cnt_q   <= stop_cnt_d;
            serial_q     <= serial_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        shift_d      = shift_q;
        tick_cnt_d   = tick_cnt_q;
        bit_idx_d    = bit_idx_q;
        stop_cnt_d   = stop_cnt_q;
        serial_d     = 1'b1;

        // Accept and unload never coincide: accept needs an empty register.
        if (tx_start && !hold_valid_q) begin
            hold_data_d  = data_in;
            hold_valid_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (hold_valid_q) begin
                    shift_d      = hold_data_q;
                    hold_valid_d = 1'b0;
                    tick_cnt_d   = 4'd0;
                    state_d      = S_START_BIT;
                end
            end
            S_START_BIT: begin
                if (tick_16x) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = 4'd0;
                        bit_idx_d  = 3'd0;
                        state_d    = S_DATA_BITS;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            S_DATA_BITS: begin
                if (tick_16x) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        shift_d    = {1'b0, shift_q[7:1]};
                        tick_cnt_d = 4'd0;
                        if (bit_idx_q == BIT_LAST) begin
                            stop_cnt_d = 5'd0;
                            state_d    = S_STOP_BIT;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            S_STOP_BIT: begin
                if (tick_16x) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        stop_cnt_d = 5'd0;
                        state_d    = S_DONE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 5'd1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // The line register follows the next state so it lines up with state_q.
        case (state_d)
            S_START_BIT: serial_d = 1'b0;
            S_DATA_BITS: serial_d = shift_d[0];
            default:     serial_d = 1'b1;
        endcase
    end

    assign serial_out    = serial_q;
    assign tx_ready      = ~hold_valid_q;
    assign tx_busy       = (state_q != S_IDLE);
    assign tx_done_pulse = (state_q == S_DONE);
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: bit-accurate frame timing checks plus a
// tick-driven receiver model feeding a byte scoreboard.
module tb_uart_tx;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_16x = 1'b0;
    logic       tx_start, tx_start2;
    logic [7:0] data_in, data_in2;
    logic       serial_out, tx_ready, tx_busy, tx_done_pulse;
    logic [2:0] state_dbg;
    logic       serial_out2, tx_ready2, tx_busy2, tx_done_pulse2;
    logic [2:0] state_dbg2;

    int checks = 0;
    int failures = 0;
    int frames_rx = 0;
    int done_cnt = 0;
    logic [7:0] exp_q[$];

    uart_tx #(.STOP_BITS(1)) dut (
        .clk(clk), .reset(reset), .tick_16x(tick_16x), .tx_start(tx_start),
        .data_in(data_in), .serial_out(serial_out), .tx_ready(tx_ready),
        .tx_busy(tx_busy), .tx_done_pulse(tx_done_pulse), .state_dbg(state_dbg)
    );

    uart_tx #(.STOP_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .tick_16x(tick_16x), .tx_start(tx_start2),
        .data_in(data_in2), .serial_out(serial_out2), .tx_ready(tx_ready2),
        .tx_busy(tx_busy2), .tx_done_pulse(tx_done_pulse2), .state_dbg(state_dbg2)
    );

    // clock / tick generation: one tick every 4 clocks, changed just after posedge
    always #5 clk = ~clk;

    int tick_div = 0;
    always @(posedge clk) begin
        #1;
        tick_div = (tick_div == 3) ? 0 : tick_div + 1;
        tick_16x = (tick_div == 0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic line(input bit sel);
        return sel ? serial_out2 : serial_out;
    endfunction

    // Holds while the line stays at v for n ticks; first_now counts the current negedge.
    task automatic measure_bit(input bit sel, input logic v, input int n,
                               input bit first_now, output bit ok);
        int cnt = 0;
        int guard = 0;
        ok = 1'b1;
        if (!first_now) @(negedge clk);
        while (guard < 4000) begin
            if (line(sel) !== v) ok = 1'b0;
            if (tick_16x) cnt++;
            if (cnt >= n) break;
            @(negedge clk);
            guard++;
        end
        if (cnt < n) ok = 1'b0;
    endtask

    task automatic check_frame(input bit sel, input logic [7:0] b, input int nstop,
                               input string tag);
        int g = 0;
        bit ok;
        while (line(sel) !== 1'b0 && g < 3000) begin
            @(negedge clk);
            g++;
        end
        chk({tag, "_start_seen"}, 32'(g < 3000), 32'd1);
        measure_bit(sel, 1'b0, 16, 1'b1, ok);
        chk({tag, "_start_bit"}, 32'(ok), 32'd1);
        for (int i = 0; i < 8; i++) begin
            measure_bit(sel, b[i], 16, 1'b0, ok);
            chk($sformatf("%s_data_bit%0d", tag, i), 32'(ok), 32'd1);
        end
        measure_bit(sel, 1'b1, 16 * nstop, 1'b0, ok);
        chk({tag, "_stop_bit"}, 32'(ok), 32'd1);
    endtask

    // driver: call at a negedge; pushes the byte only when acceptance is expected
    task automatic send(input logic [7:0] b, input bit exp_acc, input string tag);
        chk({tag, "_ready"}, 32'(tx_ready), 32'(exp_acc));
        tx_start = 1'b1;
        data_in  = b;
        if (exp_acc) exp_q.push_back(b);
        @(negedge clk);
        tx_start = 1'b0;
        data_in  = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_ticks(input int n);
        int c = 0;
        while (c < n) begin
            @(negedge clk);
            if (tick_16x) c++;
        end
    endtask

    // receiver model: mid-bit sampling on the shared tick, scoreboard compare
    int         mon_cnt = 0;
    bit         mon_active = 1'b0;
    logic [7:0] mon_byte = 8'h00;
    logic [7:0] mon_exp;

    always @(negedge clk) begin
        if (tx_done_pulse === 1'b1) done_cnt++;
        if (reset) begin
            mon_active = 1'b0;
            mon_cnt    = 0;
        end else if (!mon_active) begin
            if (serial_out === 1'b0) begin
                mon_active = 1'b1;
                mon_cnt    = tick_16x ? 1 : 0;
            end
        end else if (tick_16x) begin
            mon_cnt++;
            if (mon_cnt == 8) begin
                chk("rx_start_mid", 32'(serial_out), 32'd0);
            end else if (mon_cnt >= 24 && mon_cnt <= 136 && (mon_cnt - 24) % 16 == 0) begin
                mon_byte[(mon_cnt - 24) / 16] = serial_out;
            end else if (mon_cnt == 152) begin
                chk("rx_error_frame", 32'(serial_out), 32'd1);
                chk("rx_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_exp = exp_q.pop_front();
                    chk("rx_byte", 32'(mon_byte), 32'(mon_exp));
                end
                frames_rx++;
                mon_active = 1'b0;
            end
        end
    end

    logic [7:0] lb[4];
    int g;
    int d0;

    initial begin
        reset     = 1'b1;
        tx_start  = 1'b0;
        data_in   = 8'h00;
        tx_start2 = 1'b0;
        data_in2  = 8'h00;
        lb        = '{8'h00, 8'hFF, 8'h5A, 8'hC3};
        repeat (3) @(negedge clk);
        chk("rst_serial", 32'(serial_out), 32'd1);
        chk("rst_ready", 32'(tx_ready), 32'd1);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_done", 32'(tx_done_pulse), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'(S_IDLE));
        chk("rst_serial2", 32'(serial_out2), 32'd1);
        reset = 1'b0;
        @(negedge clk);

        // 0x55, one stop bit, with latency and done-pulse shape
        send(8'h55, 1'b1, "t1");
        chk("t1_hold_ready", 32'(tx_ready), 32'd0);
        chk("t1_hold_line", 32'(serial_out), 32'd1);
        chk("t1_hold_busy", 32'(tx_busy), 32'd0);
        @(negedge clk);
        chk("t1_load_line", 32'(serial_out), 32'd0);
        chk("t1_load_busy", 32'(tx_busy), 32'd1);
        chk("t1_load_ready", 32'(tx_ready), 32'd1);
        check_frame(1'b0, 8'h55, 1, "t1");
        @(negedge clk);
        chk("t1_done_pulse", 32'(tx_done_pulse), 32'd1);
        chk("t1_done_busy", 32'(tx_busy), 32'd1);
        @(negedge clk);
        chk("t1_done_width", 32'(tx_done_pulse), 32'd0);
        chk("t1_idle_busy", 32'(tx_busy), 32'd0);
        repeat (5) @(negedge clk);

        // back-to-back 0xA5/0x3C, drops at unload and while full
        send(8'hA5, 1'b1, "t2a");
        send(8'h11, 1'b0, "t2_unload_drop");
        fork
            check_frame(1'b0, 8'hA5, 1, "t2a");
            begin
                repeat (20) @(negedge clk);
                send(8'h3C, 1'b1, "t2b");
                chk("t2_full_ready", 32'(tx_ready), 32'd0);
                send(8'hFF, 1'b0, "t2_full_drop");
            end
        join
        @(negedge clk);
        chk("t2_gap_done", 32'(tx_done_pulse), 32'd1);
        chk("t2_gap_line1", 32'(serial_out), 32'd1);
        @(negedge clk);
        chk("t2_gap_line2", 32'(serial_out), 32'd1);
        chk("t2_gap_idle", 32'(state_dbg), 32'(S_IDLE));
        @(negedge clk);
        chk("t2_gap_start", 32'(serial_out), 32'd0);
        check_frame(1'b0, 8'h3C, 1, "t2b");
        @(negedge clk);
        chk("t2b_done", 32'(tx_done_pulse), 32'd1);
        @(negedge clk);
        chk("t2b_idle_busy", 32'(tx_busy), 32'd0);

        // two stop bits on the second instance
        tx_start2 = 1'b1;
        data_in2  = 8'h00;
        @(negedge clk);
        tx_start2 = 1'b0;
        check_frame(1'b1, 8'h00, 2, "t3");
        @(negedge clk);
        chk("t3_done", 32'(tx_done_pulse2), 32'd1);
        @(negedge clk);
        chk("t3_done_width", 32'(tx_done_pulse2), 32'd0);
        chk("t3_idle_busy", 32'(tx_busy2), 32'd0);

        // reset in data bit 3 of 0x81, then a clean resend
        send(8'h81, 1'b1, "t4");
        g = 0;
        while (serial_out !== 1'b0 && g < 3000) begin
            @(negedge clk);
            g++;
        end
        chk("t4_start_seen", 32'(g < 3000), 32'd1);
        wait_ticks(72);
        chk("t4_pre_line", 32'(serial_out), 32'd0);
        chk("t4_pre_state", 32'(state_dbg), 32'(S_DATA_BITS));
        d0 = done_cnt;
        reset = 1'b1;
        #1;
        chk("t4_rst_line", 32'(serial_out), 32'd1);
        chk("t4_rst_ready", 32'(tx_ready), 32'd1);
        chk("t4_rst_busy", 32'(tx_busy), 32'd0);
        void'(exp_q.pop_front());
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("t4_no_done", 32'(done_cnt), 32'(d0));
        chk("t4_after_line", 32'(serial_out), 32'd1);
        send(8'h81, 1'b1, "t4b");
        check_frame(1'b0, 8'h81, 1, "t4b");
        @(negedge clk);
        chk("t4b_done", 32'(tx_done_pulse), 32'd1);
        @(negedge clk);

        // back-to-back stream into the receiver model
        for (int i = 0; i < 4; i++) begin
            g = 0;
            while (tx_ready !== 1'b1 && g < 3000) begin
                @(negedge clk);
                g++;
            end
            send(lb[i], 1'b1, $sformatf("t5_b%0d", i));
        end
        g = 0;
        while ((exp_q.size() != 0 || tx_busy) && g < 20000) begin
            @(negedge clk);
            g++;
        end
        chk("t5_drain", 32'(g < 20000), 32'd1);

        chk("rx_frames", 32'(frames_rx), 32'd8);
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
